// File: rtl/hamming_stream_encoder.sv
// Hamming(7,4) stream encoder. Takes NIBBLES*4-bit words over valid/ready and emits
// one registered 7-bit codeword per nibble, least-significant nibble first.
module hamming_stream_encoder #(
  parameter int NIBBLES = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [4*NIBBLES-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [6:0]           m_code,
  output logic                 m_last,
  output logic [CNT_W-1:0]     cw_count
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_next;
  logic [4*NIBBLES-1:0] word_reg;
  logic [3:0]           next_nibble;
  logic                 handshake;
  logic                 accept;

  // Codeword layout {D7,D6,D5,P4,D3,P2,P1}, even parity.
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  assign s_ready   = !rst && (state == IDLE || (m_valid && m_ready && m_last));
  assign handshake = m_valid && m_ready;
  assign accept    = s_valid && s_ready;

  always_comb begin
    idx_next    = idx + 1'b1;
    next_nibble = 4'(word_reg >> {idx_next, 2'b00});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      word_reg <= '0;
      m_valid  <= 1'b0;
      m_code   <= '0;
      m_last   <= 1'b0;
      cw_count <= '0;
    end else begin
      if (handshake)
        cw_count <= cw_count + 1'b1;

      case (state)
        IDLE: begin
          if (accept) begin
            word_reg <= s_data;
            idx      <= '0;
            m_code   <= enc(s_data[3:0]);
            m_last   <= (NIBBLES == 1);
            m_valid  <= 1'b1;
            state    <= SEND;
          end
        end

        SEND: begin
          if (m_ready) begin
            if (idx != IDX_LAST) begin
              idx    <= idx_next;
              m_code <= enc(next_nibble);
              m_last <= (idx_next == IDX_LAST);
            end else if (s_valid) begin
              // Back-to-back word: reload without a bubble.
              word_reg <= s_data;
              idx      <= '0;
              m_code   <= enc(s_data[3:0]);
              m_last   <= (NIBBLES == 1);
            end else begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              state   <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_stream_encoder.sv
// Scoreboard bench for hamming_stream_encoder: a 2-nibble/16-bit-counter instance and a
// 1-nibble/4-bit-counter instance for wrap and m_last behaviour.
module tb_hamming_stream_encoder;

  localparam int NIB = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready, m_valid, m_ready, m_last;
  logic [7:0]  s_data;
  logic [6:0]  m_code;
  logic [15:0] cw_count;

  logic        s1_valid, s1_ready, m1_valid, m1_ready, m1_last;
  logic [3:0]  s1_data;
  logic [6:0]  m1_code;
  logic [3:0]  cw1_count;

  typedef struct packed {
    logic [3:0] nib;
    logic       last;
  } exp_t;

  exp_t        sb[$];
  int          passed = 0;
  int          total  = 0;
  bit          accepted;
  bit          flip_check = 0;
  logic [15:0] cnt_model = '0;

  always #5 clk = ~clk;

  hamming_stream_encoder #(.NIBBLES(NIB), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_code(m_code), .m_last(m_last),
    .cw_count(cw_count)
  );

  hamming_stream_encoder #(.NIBBLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .s_valid(s1_valid), .s_ready(s1_ready), .s_data(s1_data),
    .m_valid(m1_valid), .m_ready(m1_ready), .m_code(m1_code), .m_last(m1_last),
    .cw_count(cw1_count)
  );

  // Position-based Hamming model: data at positions 3,5,6,7; parity p covers positions j with j&p.
  function automatic logic [6:0] model_enc(input logic [3:0] d);
    logic [7:1] c;
    logic       x;
    c    = '0;
    c[3] = d[0];
    c[5] = d[1];
    c[6] = d[2];
    c[7] = d[3];
    for (int p = 1; p <= 4; p = p * 2) begin
      x = 1'b0;
      for (int j = 1; j < 8; j++)
        if ((j & p) != 0) x = x ^ c[j];
      c[p] = x;
    end
    return c;
  endfunction

  function automatic logic [6:0] correct(input logic [6:0] r);
    logic [2:0] s;
    logic [6:0] o;
    s = '0;
    for (int j = 1; j < 8; j++)
      if (r[j-1]) s = s ^ 3'(j);
    o = r;
    if (s != 0) o[s-1] = ~o[s-1];
    return o;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("[TB] %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic ready);
    s_valid = valid;
    s_data  = data;
    m_ready = ready;
  endtask

  // One clock: sample handshakes at the falling edge, then step past the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    accepted = 0;
    if (rst) begin
      sb.delete();
      cnt_model = '0;
    end else begin
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          checkOutput("sb_empty", 16'd1, 16'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("sb_code", 16'(m_code), 16'(model_enc(e.nib)));
          checkOutput("sb_last", 16'(m_last), 16'(e.last));
          if (flip_check)
            for (int b = 0; b < 7; b++)
              checkOutput("flip_fix", 16'(correct(m_code ^ (7'd1 << b))), 16'(m_code));
        end
        cnt_model = cnt_model + 1'b1;
      end
      if (s_valid && s_ready) begin
        for (int n = 0; n < NIB; n++)
          sb.push_back({s_data[4*n +: 4], n == NIB - 1});
        accepted = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    s1_valid = 1'b0;
    s1_data  = 4'h0;
    m1_ready = 1'b1;
    repeat (2) tick();

    checkOutput("rst_m_valid", 16'(m_valid), 16'd0);
    checkOutput("rst_m_code", 16'(m_code), 16'd0);
    checkOutput("rst_m_last", 16'(m_last), 16'd0);
    checkOutput("rst_cw_count", cw_count, 16'd0);
    checkOutput("rst_s_ready", 16'(s_ready), 16'd0);
    rst = 1'b0;
    #1;
    checkOutput("idle_s_ready", 16'(s_ready), 16'd1);

    // Single word 0x10: codes 00 then 07.
    applyStimulus(1'b1, 8'h10, 1'b1);
    tick();
    s_valid = 1'b0;
    checkOutput("w10_code0", 16'(m_code), 16'h00);
    checkOutput("w10_last0", 16'(m_last), 16'd0);
    tick();
    checkOutput("w10_code1", 16'(m_code), 16'h07);
    checkOutput("w10_last1", 16'(m_last), 16'd1);
    tick();
    checkOutput("w10_idle", 16'(m_valid), 16'd0);
    checkOutput("w10_count", cw_count, 16'd2);

    // Back-to-back words 0xB8, 0xFB.
    applyStimulus(1'b1, 8'hB8, 1'b1);
    tick();
    checkOutput("b2b_c0", 16'(m_code), 16'h4B);
    checkOutput("b2b_rdy0", 16'(s_ready), 16'd0);
    applyStimulus(1'b1, 8'hFB, 1'b1);
    tick();
    checkOutput("b2b_c1", 16'(m_code), 16'h55);
    checkOutput("b2b_rdy1", 16'(s_ready), 16'd1);
    tick();
    s_valid = 1'b0;
    checkOutput("b2b_c2", 16'(m_code), 16'h55);
    checkOutput("b2b_rdy2", 16'(s_ready), 16'd0);
    tick();
    checkOutput("b2b_c3", 16'(m_code), 16'h7F);
    checkOutput("b2b_last3", 16'(m_last), 16'd1);
    tick();
    checkOutput("b2b_idle", 16'(m_valid), 16'd0);
    checkOutput("b2b_count", cw_count, 16'd6);

    // All 16 nibbles, each codeword also checked for single-bit correctability.
    flip_check = 1;
    for (int w = 0; w < 8; w++) begin
      applyStimulus(1'b1, {4'(2*w+1), 4'(2*w)}, 1'b1);
      t = 0;
      do begin
        tick();
        t++;
      end while (!accepted && t < 8);
      checkOutput("exh_accept", 16'(accepted), 16'd1);
    end
    s_valid = 1'b0;
    repeat (3) tick();
    flip_check = 0;
    checkOutput("exh_count", cw_count, cnt_model);
    checkOutput("exh_count_abs", cw_count, 16'd22);

    // Backpressure mid-word.
    applyStimulus(1'b1, 8'h3C, 1'b0);
    tick();
    s_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_valid", 16'(m_valid), 16'd1);
      checkOutput("bp_code", 16'(m_code), 16'(model_enc(4'hC)));
      checkOutput("bp_last", 16'(m_last), 16'd0);
      checkOutput("bp_s_ready", 16'(s_ready), 16'd0);
      checkOutput("bp_count", cw_count, 16'd22);
      tick();
    end
    m_ready = 1'b1;
    repeat (3) tick();
    checkOutput("bp_idle", 16'(m_valid), 16'd0);
    checkOutput("bp_count_end", cw_count, cnt_model);

    // Reset after the first codeword of 0xB8 drops the rest of the word.
    applyStimulus(1'b1, 8'hB8, 1'b1);
    tick();
    s_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_rst_valid", 16'(m_valid), 16'd0);
    checkOutput("mid_rst_count", cw_count, 16'd0);
    checkOutput("mid_rst_code", 16'(m_code), 16'd0);
    applyStimulus(1'b1, 8'h2A, 1'b1);
    tick();
    s_valid = 1'b0;
    checkOutput("post_rst_code", 16'(m_code), 16'h52);
    repeat (3) tick();
    checkOutput("post_rst_count", cw_count, 16'd2);
    checkOutput("sb_drained", 16'(sb.size()), 16'd0);

    // NIBBLES=1, CNT_W=4: 18 codewords wrap the counter to 2.
    for (int i = 0; i < 18; i++) begin
      s1_valid = 1'b1;
      s1_data  = 4'(i);
      @(negedge clk);
      checkOutput("n1_s_ready", 16'(s1_ready), 16'd1);
      @(posedge clk);
      #1;
      checkOutput("n1_valid", 16'(m1_valid), 16'd1);
      checkOutput("n1_code", 16'(m1_code), 16'(model_enc(4'(i))));
      checkOutput("n1_last", 16'(m1_last), 16'd1);
    end
    s1_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("n1_idle", 16'(m1_valid), 16'd0);
    checkOutput("n1_wrap_count", 16'(cw1_count), 16'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
